// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control: opcodes, functs, ALU and mux selects, FSM states.
// Optional bne support is enabled elsewhere by the MC_CTRL_BNE_EN macro.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE is used in states that do not use the ALU, so ALU_ctrl idles at 000
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: maps ALUOp plus Funct to the 3-bit ALU_ctrl code.
// Shared with the single-cycle control path.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] i_aluOp,
  input  logic [5:0] i_funct,
  output logic [2:0] o_aluCtrl
);

  // Unknown R-type functs fall back to add so the ALU still produces a defined result
  always_comb begin
    o_aluCtrl = ALU_ADD;
    case (i_aluOp)
      ALUOP_ADD:  o_aluCtrl = ALU_ADD;
      ALUOP_SUB:  o_aluCtrl = ALU_SUB;
      ALUOP_NONE: o_aluCtrl = 3'b000;
      default: begin
        case (i_funct)
          FUNCT_ADD: o_aluCtrl = ALU_ADD;
          FUNCT_SUB: o_aluCtrl = ALU_SUB;
          FUNCT_AND: o_aluCtrl = ALU_AND;
          FUNCT_OR:  o_aluCtrl = ALU_OR;
          FUNCT_SLT: o_aluCtrl = ALU_SLT;
          default:   o_aluCtrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath, stalling on mem_ready.
// Define MC_CTRL_BNE_EN to accept bne (000101) as a branch on ~zero.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_ctrl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluOp;
  logic       w_memReq;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_pcWrite;
  logic       w_branch;
  logic       w_branchTaken;
  logic       w_regWrite;
  logic       w_done;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_FETCH;
    else
      r_state <= w_next;
  end

`ifdef MC_CTRL_BNE_EN
  assign w_branchTaken = (Op == OP_BNE) ? ~zero : zero;
`else
  assign w_branchTaken = zero;
`endif

  // Outputs and next state depend on the current state, plus mem_ready in the memory states
  always_comb begin
    w_next     = ST_FETCH;
    w_aluOp    = ALUOP_NONE;
    w_memReq   = 1'b0;
    w_memWrite = 1'b0;
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_branch   = 1'b0;
    w_regWrite = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    PCSrc      = PCSRC_ALURESULT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_memReq  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        w_aluOp   = ALUOP_ADD;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
        w_next    = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        w_aluOp = ALUOP_ADD;
        case (Op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_EXEC;
          OP_BEQ:       w_next = ST_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_next = ST_BRANCH;
`endif
          OP_ADDI:      w_next = ST_ADDIEX;
          OP_J:         w_next = ST_JUMP;
          default: begin
            w_next    = ST_FETCH;
            w_illegal = 1'b1;
            w_done    = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_aluOp = ALUOP_ADD;
        w_next  = (Op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        w_memReq = 1'b1;
        IorD     = 1'b1;
        w_next   = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regWrite = 1'b1;
        w_done     = 1'b1;
      end
      ST_MEMWR: begin
        w_memReq   = 1'b1;
        IorD       = 1'b1;
        w_memWrite = 1'b1;
        w_done     = mem_ready;
        w_next     = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        w_aluOp = ALUOP_FUNCT;
        w_next  = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegDst     = 1'b1;
        w_regWrite = 1'b1;
        w_done     = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluOp  = ALUOP_SUB;
        PCSrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
        w_done   = 1'b1;
      end
      ST_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_aluOp = ALUOP_ADD;
        w_next  = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_regWrite = 1'b1;
        w_done     = 1'b1;
      end
      ST_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        w_pcWrite = 1'b1;
        w_done    = 1'b1;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  alu_decoder u_aluDecoder (
    .i_aluOp   (w_aluOp),
    .i_funct   (Funct),
    .o_aluCtrl (ALU_ctrl)
  );

  // Reset suppresses every side-effecting strobe so an abandoned instruction writes nothing
  assign mem_req    = w_memReq & ~reset;
  assign MemWrite   = w_memWrite & ~reset;
  assign IRWrite    = w_irWrite & ~reset;
  assign PCEn       = (w_pcWrite | (w_branch & w_branchTaken)) & ~reset;
  assign RegWrite   = w_regWrite & ~reset;
  assign instr_done = w_done & ~reset;
  assign illegal    = w_illegal & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours MC_CTRL_BNE_EN for the bne case.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, IorD, MemWrite, IRWrite, PCEn;
  logic [1:0] PCSrc, ALUSrcB;
  logic       ALUSrcA;
  logic [2:0] ALU_ctrl;
  logic       RegDst, MemtoReg, RegWrite, instr_done, illegal;

  int checks = 0;
  int failures = 0;
  int doneCount;
  int regWrCount;
  int cyc;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_ctrl(ALU_ctrl),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
    Op = op;
    Funct = fn;
    zero = z;
    mem_ready = rdy;
    #1;
  endtask

  // Runs one instruction from FETCH with zero-wait memory and returns its cycle count
  task automatic runCount(input logic [5:0] op, input logic [5:0] fn, input logic z, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      applyStimulus(op, fn, z, 1'b1);
      n++;
      seen = instr_done;
      step();
    end
    if (!seen) checkOutput("count_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_IRWrite", IRWrite, 0);
      checkOutput("rst_PCEn", PCEn, 0);
    end
    checkOutput("rst_state", dut.r_state, ST_FETCH);

    // lw, zero wait
    reset = 1'b0;
    doneCount = 0;
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_c1_state", dut.r_state, ST_FETCH);
    checkOutput("lw_c1_IRWrite", IRWrite, 1);
    checkOutput("lw_c1_PCEn", PCEn, 1);
    checkOutput("lw_c1_ALUSrcB", ALUSrcB, 2'b01);
    doneCount += int'(instr_done);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_c2_state", dut.r_state, ST_DECODE);
    checkOutput("lw_c2_ALUSrcB", ALUSrcB, 2'b11);
    doneCount += int'(instr_done);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_c3_state", dut.r_state, ST_MEMADR);
    checkOutput("lw_c3_ALUSrcA", ALUSrcA, 1);
    doneCount += int'(instr_done);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_c4_state", dut.r_state, ST_MEMRD);
    checkOutput("lw_c4_IorD", IorD, 1);
    checkOutput("lw_c4_mem_req", mem_req, 1);
    doneCount += int'(instr_done);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("lw_c5_state", dut.r_state, ST_MEMWB);
    checkOutput("lw_c5_RegWrite", RegWrite, 1);
    checkOutput("lw_c5_MemtoReg", MemtoReg, 1);
    doneCount += int'(instr_done);
    checkOutput("lw_done_pulses", doneCount, 1);
    step();

    // sw with two wait cycles in MEMWR
    regWrCount = 0;
    applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
    regWrCount += int'(RegWrite);
    step(); applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
    regWrCount += int'(RegWrite);
    step(); applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
    regWrCount += int'(RegWrite);
    step(); applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
    checkOutput("sw_w1_state", dut.r_state, ST_MEMWR);
    checkOutput("sw_w1_MemWrite", MemWrite, 1);
    checkOutput("sw_w1_done", instr_done, 0);
    regWrCount += int'(RegWrite);
    step(); applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
    checkOutput("sw_w2_MemWrite", MemWrite, 1);
    checkOutput("sw_w2_done", instr_done, 0);
    regWrCount += int'(RegWrite);
    step(); applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
    checkOutput("sw_w3_MemWrite", MemWrite, 1);
    checkOutput("sw_w3_done", instr_done, 1);
    regWrCount += int'(RegWrite);
    checkOutput("sw_no_regwrite", regWrCount, 0);
    step();
    checkOutput("sw_back_fetch", dut.r_state, ST_FETCH);

    // R-type sub
    applyStimulus(OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1);
    step(); applyStimulus(OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1);
    step(); applyStimulus(OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1);
    checkOutput("rt_exec_state", dut.r_state, ST_EXEC);
    checkOutput("rt_exec_alu", ALU_ctrl, 3'b110);
    Funct = FUNCT_SLT; #1;
    checkOutput("rt_exec_slt", ALU_ctrl, 3'b111);
    Funct = 6'b111111; #1;
    checkOutput("rt_exec_unknown", ALU_ctrl, 3'b010);
    step(); applyStimulus(OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1);
    checkOutput("rt_wb_RegDst", RegDst, 1);
    checkOutput("rt_wb_RegWrite", RegWrite, 1);
    checkOutput("rt_wb_done", instr_done, 1);
    step();
    runCount(OP_RTYPE, FUNCT_ADD, 1'b0, cyc);
    checkOutput("rt_cycles", cyc, 4);

    // beq taken / not taken
    applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
    step(); applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
    step(); applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
    checkOutput("beq_state", dut.r_state, ST_BRANCH);
    checkOutput("beq_t_PCEn", PCEn, 1);
    checkOutput("beq_t_PCSrc", PCSrc, 2'b01);
    checkOutput("beq_t_alu", ALU_ctrl, 3'b110);
    zero = 1'b0; #1;
    checkOutput("beq_nt_PCEn", PCEn, 0);
    step();
    runCount(OP_BEQ, 6'd0, 1'b1, cyc);
    checkOutput("beq_t_cycles", cyc, 3);
    runCount(OP_BEQ, 6'd0, 1'b0, cyc);
    checkOutput("beq_nt_cycles", cyc, 3);
    runCount(OP_LW, 6'd0, 1'b0, cyc);
    checkOutput("lw_cycles", cyc, 5);
    runCount(OP_SW, 6'd0, 1'b0, cyc);
    checkOutput("sw_cycles", cyc, 4);
    runCount(OP_ADDI, 6'd0, 1'b0, cyc);
    checkOutput("addi_cycles", cyc, 4);
    runCount(OP_J, 6'd0, 1'b0, cyc);
    checkOutput("j_cycles", cyc, 3);

    // jump strobes
    applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
    checkOutput("j_PCSrc", PCSrc, 2'b10);
    checkOutput("j_PCEn", PCEn, 1);
    step();

    // illegal opcode
    applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
    checkOutput("ill_illegal", illegal, 1);
    checkOutput("ill_done", instr_done, 1);
    step();
    checkOutput("ill_next_fetch", dut.r_state, ST_FETCH);

    // bne
    applyStimulus(OP_BNE, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_BNE, 6'd0, 1'b0, 1'b1);
`ifdef MC_CTRL_BNE_EN
    checkOutput("bne_illegal", illegal, 0);
    step(); applyStimulus(OP_BNE, 6'd0, 1'b0, 1'b1);
    checkOutput("bne_state", dut.r_state, ST_BRANCH);
    checkOutput("bne_PCEn", PCEn, 1);
    zero = 1'b1; #1;
    checkOutput("bne_nt_PCEn", PCEn, 0);
    step();
`else
    checkOutput("bne_illegal", illegal, 1);
    checkOutput("bne_done", instr_done, 1);
    step();
    checkOutput("bne_next_fetch", dut.r_state, ST_FETCH);
`endif

    // reset in the middle of a load
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
    checkOutput("mr_state", dut.r_state, ST_MEMRD);
    reset = 1'b1;
    applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("mr_rst_mem_req", mem_req, 0);
    checkOutput("mr_rst_RegWrite", RegWrite, 0);
    step(); applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
    checkOutput("mr_rst_state", dut.r_state, ST_FETCH);
    checkOutput("mr_rst_IRWrite", IRWrite, 0);
    checkOutput("mr_rst_PCEn", PCEn, 0);
    checkOutput("mr_rst_RegWrite2", RegWrite, 0);
    reset = 1'b0; #1;
    checkOutput("mr_rel_IRWrite", IRWrite, 1);
    step();
    checkOutput("mr_rel_decode", dut.r_state, ST_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath. It decodes opcode/funct from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable of the datapath and stalls on a single-port memory ready handshake. It sits beside the datapath at top level, replacing the single-cycle combinational control.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `Op` in 6: instruction[31:26] from the instruction register.
- `Funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access in progress.
- `IorD` out 1: address mux, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write.
- `IRWrite` out 1: instruction register load.
- `PCEn` out 1: PC load; `PCWrite | (Branch & zero-condition)`.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` out 1: 0 = PC, 1 = RD1.
- `ALUSrcB` out 2: 00 = RD2, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALU_ctrl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `MemtoReg` out 1: 0 = ALUOut, 1 = Data.
- `RegWrite` out 1: register file write.
- `instr_done` out 1: one-cycle pulse on an instruction's final cycle.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- **FETCH**
  - Outputs: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_ctrl=add, PCSrc=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0, then goes to DECODE.
- **DECODE**
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALU_ctrl=add (branch target into ALUOut).
  - Opcode dispatch:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 → EXEC
    - beq 000100 → BRANCH
    - addi 001000 → ADDIEX
    - j 000010 → JUMP
    - any other opcode → FETCH, with illegal=1 and instr_done=1
- **MEMADR**
  - Outputs: ALUSrcA=1, ALUSrcB=10, add.
  - Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD**: mem_req=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- **MEMWB**: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- **MEMWR**
  - Outputs: mem_req=1, IorD=1, MemWrite=1, held until mem_ready.
  - On mem_ready: instr_done=1, go to FETCH.
- **EXEC**
  - Outputs: ALUSrcA=1, ALUSrcB=00.
  - ALU_ctrl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other Funct gives add.
  - Goes to ALUWB.
- **ALUWB**: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1.
  - PCEn = zero.
  - instr_done=1; goes to FETCH.
- **ADDIEX**: ALUSrcA=1, ALUSrcB=10, add. Goes to ADDIWB.
- **ADDIWB**: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- **JUMP**: PCSrc=10, PCWrite=1, instr_done=1. Goes to FETCH.
- All unlisted outputs are 0 in each state. Unreachable state encodings return to FETCH.

## Timing
- Outputs are combinational from state (plus mem_ready and zero where stated). State is registered on the rising edge of clk.
- Cycles per instruction, with zero-wait memory:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset:
  - reset=1 forces the state to FETCH on the next edge.
  - While reset=1, IRWrite, PCEn, RegWrite, MemWrite, mem_req, instr_done and illegal are forced to 0.
  - The first fetch starts in the first cycle with reset=0.
  - Reset mid-instruction abandons it with no register or memory write.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

## Configuration
- `MC_CTRL_BNE_EN`
  - Defined: opcode 000101 (bne) dispatches to BRANCH with PCEn = ~zero.
  - Undefined: 000101 is illegal (illegal=1, return to FETCH).

## Structure
- Package `mips_pkg` holds:
  - opcode and funct localparams;
  - the state enum typedef;
  - ALU_ctrl encodings;
  - PCSrc / ALUSrcB select encodings.
- One sub-module, `alu_decoder`, maps (state-derived ALUOp, Funct) to ALU_ctrl. It is combinational and reusable by the single-cycle control.

## Test plan
- reset held 3 cycles, then released with mem_ready=1 and Op=100011: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=1 in cycle 5; instr_done pulses exactly once.
- sw with mem_ready low for 2 cycles in MEMWR: MemWrite held for 3 cycles; instr_done coincides with the mem_ready cycle; no RegWrite.
- R-type Funct=100010: ALU_ctrl=110 in EXEC; RegDst=1 and RegWrite=1 in ALUWB; 4 cycles total.
- beq with zero=1 → PCEn=1 and PCSrc=01 in BRANCH; with zero=0 → PCEn=0; both take 3 cycles.
- Op=111111 → illegal=1 in DECODE, next state FETCH. Op=000101 with the macro off behaves the same; with the macro on and zero=0, PCEn=1.
- reset asserted in MEMRD → no RegWrite, next state FETCH; all enables stay 0 while reset is high.
